// File: rtl/full_adder_pkg.sv
// Shared constants and types for the registered full-adder bit-slice.
package full_adder_pkg;

    // Reset values of the registered outputs
    localparam logic SUM_RST   = 1'b0;
    localparam logic COUT_RST  = 1'b0;
    localparam logic VALID_RST = 1'b0;

    // Two-bit adder result packed as {carry, sum}
    typedef logic [1:0] fa_result_t;

    // Pack separate carry and sum bits into a result word
    function automatic fa_result_t fa_pack(input logic carry, input logic sum_bit);
        return {carry, sum_bit};
    endfunction

endpackage

// File: rtl/full_adder_core.sv
// Purely combinational gate-level 1-bit full adder. Also used directly by
// combinational ripple chains, so it carries no clock or reset.
module full_adder_core (
    input  logic in1,
    input  logic in2,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    logic half_sum;

    assign half_sum = in1 ^ in2;
    assign sum      = half_sum ^ c_in;
    assign c_out    = (in1 & in2) | (c_in & half_sum);

endmodule

// File: rtl/full_adder.sv
// Registered 1-bit full adder slice: one-cycle latency, valid-qualified capture.
// Optional macro FULL_ADDER_SELFCHECK_EN compiles a behavioural reference that
// cross-checks the gate-level core and raises a sticky err flag on mismatch.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int HOLD_ON_IDLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in1,
    input  logic in2,
    input  logic c_in,
    output logic sum,
    output logic c_out,
    output logic out_valid,
    output logic err
);

    logic       core_sum;
    logic       core_c_out;
    fa_result_t res_p1;
    logic       vld_p1;

    full_adder_core u_core (
        .in1   (in1),
        .in2   (in2),
        .c_in  (c_in),
        .sum   (core_sum),
        .c_out (core_c_out)
    );

    // Stage p0 -> p1: capture core result on valid; hold or clear when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_p1 <= fa_pack(COUT_RST, SUM_RST);
            vld_p1 <= VALID_RST;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                res_p1 <= fa_pack(core_c_out, core_sum);
            end else if (HOLD_ON_IDLE == 0) begin
                res_p1 <= fa_pack(1'b0, 1'b0);
            end
        end
    end

    assign sum       = res_p1[0];
    assign c_out     = res_p1[1];
    assign out_valid = vld_p1;

`ifdef FULL_ADDER_SELFCHECK_EN
    fa_result_t ref_res;
    logic       err_p1;

    assign ref_res = fa_result_t'({1'b0, in2} + {1'b0, in1} + {1'b0, c_in});

    // Sticky mismatch flag, registered alongside the data it checks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_p1 <= 1'b0;
        end else if (in_valid && (ref_res != fa_pack(core_c_out, core_sum))) begin
            err_p1 <= 1'b1;
        end
    end

    assign err = err_p1;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: exhaustive sweep, idle hold/clear,
// asynchronous reset, release, self-check fault and random traffic.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in1 = 1'b0;
    logic in2 = 1'b0;
    logic c_in = 1'b0;

    logic sum_h, c_out_h, out_valid_h, err_h;
    logic sum_c, c_out_c, out_valid_c, err_c;

    int total = 0;
    int bad = 0;

    // reference model state: hold and clear variants
    int exp_sum_h = 0, exp_cout_h = 0;
    int exp_sum_c = 0, exp_cout_c = 0;
    int exp_vld = 0;
    int exp_err = 0;
    bit selfcheck = 1'b0;

    always #5 clk = ~clk;

    full_adder #(.HOLD_ON_IDLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in1(in1), .in2(in2), .c_in(c_in),
        .sum(sum_h), .c_out(c_out_h), .out_valid(out_valid_h), .err(err_h)
    );

    full_adder #(.HOLD_ON_IDLE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in1(in1), .in2(in2), .c_in(c_in),
        .sum(sum_c), .c_out(c_out_c), .out_valid(out_valid_c), .err(err_c)
    );

    task automatic check(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_sum_h = 0; exp_cout_h = 0;
        exp_sum_c = 0; exp_cout_c = 0;
        exp_vld = 0;   exp_err = 0;
    endtask

    task automatic check_all(input string tag, input bit data_too);
        if (data_too) begin
            check({tag, ".sum_h"},   sum_h,   exp_sum_h[0]);
            check({tag, ".cout_h"},  c_out_h, exp_cout_h[0]);
        end
        check({tag, ".sum_c"},   sum_c,       exp_sum_c[0]);
        check({tag, ".cout_c"},  c_out_c,     exp_cout_c[0]);
        check({tag, ".vld_h"},   out_valid_h, exp_vld[0]);
        check({tag, ".vld_c"},   out_valid_c, exp_vld[0]);
        check({tag, ".err_h"},   err_h,       exp_err[0]);
        check({tag, ".err_c"},   err_c,       1'b0);
    endtask

    // Drive one cycle of input, advance the model at the edge, check after it
    task automatic step(input string tag, input logic v, input logic a,
                        input logic b, input logic c, input bit data_too);
        int total_bits;
        @(negedge clk);
        in_valid = v; in1 = a; in2 = b; c_in = c;
        @(posedge clk);
        total_bits = int'(a) + int'(b) + int'(c);
        exp_vld = int'(v);
        if (v) begin
            exp_sum_h = total_bits % 2; exp_cout_h = total_bits / 2;
            exp_sum_c = total_bits % 2; exp_cout_c = total_bits / 2;
        end else begin
            exp_sum_c = 0; exp_cout_c = 0;
        end
        #1;
        check_all(tag, data_too);
    endtask

    initial begin
        logic [2:0] combo;
        logic [1:0] seq_req [8];
        seq_req = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
`ifdef FULL_ADDER_SELFCHECK_EN
        selfcheck = 1'b1;
`endif
        // reset state
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all("reset", 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // exhaustive sweep against fixed table and model
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            step("sweep", 1'b1, combo[2], combo[1], combo[0], 1'b1);
            check("sweep.table", (c_out_h == seq_req[i][1]) && (sum_h == seq_req[i][0]), 1'b1);
        end

        // idle hold / clear
        step("idle_load", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // asynchronous reset between edges while outputs show 1/1
        step("pre_rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst", 1'b1);

        // release and capture 0,1,1
        @(negedge clk);
        rst = 1'b0;
        step("release", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check("release.cout_lit", c_out_h, 1'b1);
        check("release.sum_lit", sum_h, 1'b0);

        // forced core fault on the hold instance
        force dut.core_c_out = 1'b1;
        exp_err = selfcheck ? 1 : 0;
        step("fault", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        release dut.core_c_out;
        for (int i = 0; i < 3; i++) step("fault_sticky", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

        // reset clears the sticky flag
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("err_rst", 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // random traffic
        for (int i = 0; i < 60; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/full_adder.md
# full_adder

Registered 1-bit full adder used as the bit-slice of the ripple-carry adder datapath. It adds operand bits `in1` and `in2` plus carry-in `c_in`, producing `sum` and `c_out`. The results are registered behind a valid strobe so slices can be pipelined or chained at a known latency. The arithmetic is a small combinational core. An optional self-check compares that core against a behavioural reference.

## Interface
Parameters:
- `HOLD_ON_IDLE`, default 1. When 1, the outputs keep their last result while `in_valid` is low. When 0, the outputs clear to 0 on an idle cycle.

Ports:
- `clk`, input, 1 bit: rising-edge clock. The block has one clock.
- `rst`, input, 1 bit: reset, asynchronous, active-high.
- `in_valid`, input, 1 bit: qualifies `in1`, `in2` and `c_in` in the current cycle.
- `in1`, input, 1 bit: operand A bit.
- `in2`, input, 1 bit: operand B bit.
- `c_in`, input, 1 bit: carry-in.
- `sum`, output, 1 bit: registered sum, `in1 ^ in2 ^ c_in`.
- `c_out`, output, 1 bit: registered carry, `(in1 & in2) | (c_in & (in1 ^ in2))`.
- `out_valid`, output, 1 bit: high for one cycle per accepted input.
- `err`, output, 1 bit: sticky self-check mismatch flag.

## Operation
- Combinational core: `{c_out_n, sum_n} = in1 + in2 + c_in`, a 2-bit result in the range 0..3.
  - The core is built from XOR/AND/OR gates.
  - Inputs of X/Z are not supported.
- Rising edge with `in_valid` = 1: load `sum` and `c_out` from the core, and set `out_valid` to 1.
- Rising edge with `in_valid` = 0:
  - `out_valid` goes to 0.
  - `sum` and `c_out` hold if `HOLD_ON_IDLE` = 1, otherwise they clear to 0.
- Back-to-back valid cycles are accepted every cycle. There is no backpressure and no stall.
- Reset values: `sum` = 0, `c_out` = 0, `out_valid` = 0, `err` = 0.
- Reset asserted mid-stream: all outputs clear immediately (asynchronously). The input of the cycle in which `rst` is released is not captured. Capture resumes on the first rising edge with `rst` low.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on `sum`, `c_out` and `out_valid` after edge N.
- Throughput is 1 result per cycle.
- `out_valid` is a single-cycle pulse per accepted input. Consecutive inputs keep it continuously high.
- No combinational path from any input to any output.
- `err`:
  - Registered on the same edge as the data it checks.
  - Once set, it stays set until `rst`.

## Configuration
- Macro `FULL_ADDER_SELFCHECK_EN`.
- Defined:
  - A behavioural reference computes `{in2 + in1 + c_in}`.
  - On every accepted input it is compared with the gate-level core.
  - On a mismatch, `err` is set to 1 at that edge and stays set until `rst`.
- Undefined:
  - The reference and comparator are not compiled.
  - `err` is tied to constant 0.
  - The port list is the same in both cases.

## Structure
- Package `full_adder_pkg` holds:
  - Reset constants `SUM_RST` = 0, `COUT_RST` = 0, `VALID_RST` = 0.
  - A 2-bit typedef `fa_result_t` for `{carry, sum}`.
- Sub-module `full_adder_core`:
  - Purely combinational gate-level adder with ports `in1`, `in2`, `c_in`, `sum`, `c_out`.
  - It is also instantiated directly by combinational ripple chains.
- The top level holds only the capture registers, the valid flop and the optional checker.

## Test plan
- Exhaustive: drive all 8 combinations of (`in1`, `in2`, `c_in`) from 000 to 111, one per cycle with `in_valid` = 1. The required `{c_out, sum}` sequence is 00, 01, 01, 10, 01, 10, 10, 11. Each result appears one cycle after its input, with `out_valid` high throughout.
- Idle hold: input 1,1,1 with `in_valid` = 1, then 3 cycles with `in_valid` = 0.
  - `HOLD_ON_IDLE` = 1: `sum` = 1 and `c_out` = 1 hold, and `out_valid` = 0 for those 3 cycles.
  - `HOLD_ON_IDLE` = 0: both clear to 0.
- Reset mid-stream: assert `rst` between clock edges while the outputs show 1/1. `sum`, `c_out` and `out_valid` go to 0 immediately, before the next edge.
- Release: deassert `rst` and drive 0,1,1 with `in_valid` = 1. `sum` = 0 and `c_out` = 1 appear one cycle later.
- Self-check (macro defined): run the exhaustive sweep; `err` stays 0. Force a wrong `full_adder_core` carry; `err` becomes 1 at that edge and stays 1 until `rst`.
- Self-check (macro undefined): `err` is 0 for the whole exhaustive sweep and under a forced fault.
